uart_upg_loader: RTL and testbench

//  UART programming loader feeding the upg_* port of cpu_top's instruction ROM and data memory.

---
 rtl/uart_upg_loader_if.sv | 20 ++
 rtl/uart_upg_loader.sv | 205 ++++++++++++++++++++
 tb/tb_uart_upg_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_upg_loader_if.sv
// Memory-programming port driven by the UART loader.
// master: the loader, which drives every signal.
// slave : the consumer (cpu_top instruction ROM / data memory and its program-mode gate).
//  upg_wen_o   one-cycle write strobe; address and data are valid in the same cycle
//  upg_adr_o   [14] region (0 instruction ROM, 1 data RAM), [13:0] word address
//  upg_dat_o   assembled little-endian word
//  upg_done_o  high once the last word of a frame has been written
//  upg_err_o   one-cycle pulse on a rejected header, byte or checksum
interface uart_upg_loader_if;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        upg_err_o;

  modport master (output upg_wen_o, output upg_adr_o, output upg_dat_o,
                  output upg_done_o, output upg_err_o);
  modport slave  (input  upg_wen_o, input  upg_adr_o, input  upg_dat_o,
                  input  upg_done_o, input  upg_err_o);
endinterface

// File: rtl/uart_upg_loader.sv
// UART programming loader. It receives 8N1 bytes from the host and parses frames of the form
// CMD ('I' or 'D'), CNT_L, CNT_H, then 4*N little-endian data bytes. Each assembled word is
// written through a one-cycle strobe on the upg port.
// Ports:
//  clk   loader clock; all logic runs on its rising edge
//  rst   asynchronous, active-low reset
//  rx_i  serial input, idle high, LSB first
//  upg   uart_upg_loader_if.master: write strobe, address, data, done, err
// Optional feature: define UPG_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module uart_upg_loader #(
  parameter int CLK_FREQ_HZ = 23_000_000,
  parameter int BAUD        = 128_000,
  parameter int OVS         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  uart_upg_loader_if.master upg
);
  localparam int DIV  = CLK_FREQ_HZ / (BAUD * OVS);
  localparam int DW   = $clog2(DIV);
  localparam int OW   = (OVS > 2) ? $clog2(OVS) : 1;
  localparam int HALF = OVS / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {F_IDLE, F_CNT0, F_CNT1, F_DATA, F_CHK, F_DONE} fr_st_t;

`ifdef UPG_CHECKSUM_EN
  localparam fr_st_t F_POST = F_CHK;
`else
  localparam fr_st_t F_POST = F_DONE;
`endif

  logic          r_rx_s1, r_rx_s2, r_rx_s3;
  logic [DW-1:0] r_div;
  logic [OW-1:0] r_ovs;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_byte_vld, r_fr_err;
  rx_st_t        r_rx_st, w_rx_nxt;
  logic          w_tick, w_fall, w_ovs_end;

  assign w_tick    = (r_div == DW'(DIV - 1));
  assign w_fall    = r_rx_s3 & ~r_rx_s2;
  assign w_ovs_end = w_tick && (r_ovs == OW'(OVS - 1));

  // RX stage: synchronizer, oversampling divider and bit sampler
  always_comb begin
    w_rx_nxt = r_rx_st;
    case (r_rx_st)
      RX_IDLE:  if (w_fall) w_rx_nxt = RX_START;
      // Mid-start-bit re-check rejects glitches on the line.
      RX_START: if (w_tick && r_ovs == OW'(HALF - 1)) w_rx_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_ovs_end && r_bit == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP:  if (w_ovs_end) w_rx_nxt = RX_IDLE;
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_s3 <= 1'b1;
      r_rx_st <= RX_IDLE;
      r_div <= '0; r_ovs <= '0; r_bit <= '0;
      r_byte_vld <= 1'b0; r_fr_err <= 1'b0;
    end else begin
      r_rx_s1 <= rx_i; r_rx_s2 <= r_rx_s1; r_rx_s3 <= r_rx_s2;
      r_rx_st <= w_rx_nxt;
      r_byte_vld <= 1'b0;
      r_fr_err   <= 1'b0;
      // Divider phase restarts at each start edge so sampling stays bit-centred.
      if (r_rx_st == RX_IDLE) begin
        r_div <= '0; r_ovs <= '0; r_bit <= '0;
      end else begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          if ((r_rx_st == RX_START && r_ovs == OW'(HALF - 1)) || r_ovs == OW'(OVS - 1))
            r_ovs <= '0;
          else
            r_ovs <= r_ovs + 1'b1;
        end
        if (r_rx_st == RX_DATA && w_ovs_end) r_bit <= r_bit + 3'd1;
        if (r_rx_st == RX_STOP && w_ovs_end) begin
          r_byte_vld <= r_rx_s2;
          r_fr_err   <= ~r_rx_s2;
        end
      end
    end
  end

  always_ff @(posedge clk)
    if (r_rx_st == RX_DATA && w_ovs_end) r_shift <= {r_rx_s2, r_shift[7:1]};

  // Frame stage: header parse, word assembly and write strobe
  fr_st_t      r_fs, w_fs_nxt;
  logic        r_region, r_wen, r_done, r_err;
  logic [7:0]  r_cnt_l;
  logic [14:0] r_cnt, r_widx;
  logic [1:0]  r_bidx;
  logic [23:0] r_word;
  logic [14:0] r_adr;
  logic [31:0] r_dat;
  logic        w_cmd_ok, w_last, w_hdr_err;
  logic [15:0] w_cnt;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  assign w_cmd_ok = (r_shift == 8'h49) || (r_shift == 8'h44);
  assign w_cnt    = {r_shift, r_cnt_l};
  assign w_last   = (r_widx + 15'd1) == r_cnt;

  always_comb begin
    w_fs_nxt  = r_fs;
    w_hdr_err = 1'b0;
    if (r_byte_vld) begin
      case (r_fs)
        F_IDLE, F_DONE: if (w_cmd_ok) w_fs_nxt = F_CNT0; else w_hdr_err = 1'b1;
        F_CNT0: w_fs_nxt = F_CNT1;
        F_CNT1: begin
          if (w_cnt > 16'd16384) begin
            w_fs_nxt  = F_IDLE;
            w_hdr_err = 1'b1;
          end else if (w_cnt == 16'd0) begin
            w_fs_nxt = F_POST;
          end else begin
            w_fs_nxt = F_DATA;
          end
        end
        F_DATA: if (r_bidx == 2'd3 && w_last) w_fs_nxt = F_POST;
`ifdef UPG_CHECKSUM_EN
        F_CHK: begin
          if (r_shift == r_xor) w_fs_nxt = F_DONE;
          else begin
            w_fs_nxt  = F_IDLE;
            w_hdr_err = 1'b1;
          end
        end
`endif
        default: w_fs_nxt = F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fs <= F_IDLE; r_region <= 1'b0; r_wen <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
      r_cnt_l <= '0; r_cnt <= '0; r_widx <= '0; r_bidx <= '0;
      r_adr <= '0; r_dat <= '0;
`ifdef UPG_CHECKSUM_EN
      r_xor <= '0;
`endif
    end else begin
      r_fs  <= w_fs_nxt;
      r_wen <= 1'b0;
      r_err <= w_hdr_err | r_fr_err;
      // Done tracks residence in DONE: set on entry, cleared by the next accepted CMD.
      r_done <= (w_fs_nxt == F_DONE);
      if (r_byte_vld) begin
        case (r_fs)
          F_IDLE, F_DONE: begin
            if (w_cmd_ok) r_region <= (r_shift == 8'h44);
`ifdef UPG_CHECKSUM_EN
            r_xor <= '0;
`endif
          end
          F_CNT0: r_cnt_l <= r_shift;
          F_CNT1: begin
            r_cnt  <= w_cnt[14:0];
            r_widx <= '0;
            r_bidx <= '0;
          end
          F_DATA: begin
            r_bidx <= r_bidx + 2'd1;
`ifdef UPG_CHECKSUM_EN
            r_xor <= r_xor ^ r_shift;
`endif
            if (r_bidx == 2'd3) begin
              r_wen  <= 1'b1;
              r_adr  <= {r_region, r_widx[13:0]};
              r_dat  <= {r_shift, r_word};
              r_widx <= r_widx + 15'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk)
    if (r_byte_vld && r_fs == F_DATA)
      case (r_bidx)
        2'd0:    r_word[7:0]   <= r_shift;
        2'd1:    r_word[15:8]  <= r_shift;
        2'd2:    r_word[23:16] <= r_shift;
        default: ;
      endcase

  assign upg.upg_wen_o  = r_wen;
  assign upg.upg_adr_o  = r_adr;
  assign upg.upg_dat_o  = r_dat;
  assign upg.upg_done_o = r_done;
  assign upg.upg_err_o  = r_err;
endmodule

// File: tb/tb_uart_upg_loader.sv
// Bench for uart_upg_loader: directed frames plus randomized frames, compared against
// expected writes derived directly from the word lists that were serialized.
module tb_uart_upg_loader;
  localparam int CLK_HZ = 3_200_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  uart_upg_loader_if upg();

  uart_upg_loader #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .OVS(16)) dut (
    .clk (clk),
    .rst (rst),
    .rx_i(rx),
    .upg (upg)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [63:0] cap_q[$];
  logic [31:0] tx_words[$];
  int err_seen = 0, wen_run = 0, wen_bad = 0, err_run = 0, err_bad = 0;

  always @(negedge clk) begin
    if (upg.upg_wen_o) begin
      cap_q.push_back({17'd0, upg.upg_adr_o, upg.upg_dat_o});
      wen_run++;
    end else begin
      if (wen_run > 1) wen_bad++;
      wen_run = 0;
    end
    if (upg.upg_err_o) begin
      err_seen++;
      err_run++;
    end else begin
      if (err_run > 1) err_bad++;
      err_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (BIT) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wen"},  upg.upg_wen_o, 0);
    chk({tag, "_adr"},  upg.upg_adr_o, 0);
    chk({tag, "_dat"},  upg.upg_dat_o, 0);
    chk({tag, "_done"}, upg.upg_done_o, 0);
    chk({tag, "_err"},  upg.upg_err_o, 0);
  endtask

  // Sends cmd + count + the words in tx_words (LSB byte first). A bad-stop byte is
  // injected before data byte position bad_pos (none when negative).
  task automatic run_frame(input string tag, input logic [7:0] cmd, input int bad_pos);
    int n, e0;
    logic [7:0] x, b;
    logic [63:0] ev;
    logic rg;
    cap_q.delete();
    e0 = err_seen;
    n  = tx_words.size();
    x  = 8'h00;
    rg = (cmd == 8'h44);
    send_byte(cmd, 1'b1);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        if (4 * i + k == bad_pos) send_byte(8'hA5, 1'b0);
        b = tx_words[i][8*k +: 8];
        x = x ^ b;
        send_byte(b, 1'b1);
      end
`ifdef UPG_CHECKSUM_EN
    send_byte(x, 1'b1);
`endif
    repeat (4) @(negedge clk);
    chk({tag, "_nwr"}, cap_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < cap_q.size()) begin
        ev = {17'd0, rg, 14'(i), tx_words[i]};
        chk({tag, "_wr"}, cap_q[i], ev);
      end
    chk({tag, "_done"}, upg.upg_done_o, 1);
    chk({tag, "_err"}, err_seen - e0, (bad_pos >= 0) ? 1 : 0);
  endtask

  initial begin
    int e0, n, bp;
    rx  = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_outputs_zero("rst");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_outputs_zero("post_rst");

    tx_words = '{32'h0000_0013, 32'h0010_02B7};
    run_frame("instr2", 8'h49, -1);

    tx_words = '{32'hDEAD_BEEF};
    run_frame("data1", 8'h44, -1);

    // Reset in the middle of a byte (start bit plus data bits 0..3 already sent).
    rx = 1'b0;
    repeat (BIT * 5) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("midrst");
    rst = 1'b1;
    repeat (BIT) @(negedge clk);
    tx_words = '{32'h0000_0013, 32'h0010_02B7};
    run_frame("after_rst", 8'h49, -1);

    // Bad stop bit in the middle of the data bytes.
    tx_words = '{32'h4433_2211};
    run_frame("badstop", 8'h49, 1);

    // Unknown command byte, then an empty frame.
    e0 = err_seen;
    send_byte(8'h58, 1'b1);
    repeat (4) @(negedge clk);
    chk("x_err", err_seen - e0, 1);
    tx_words.delete();
    run_frame("empty", 8'h49, -1);

    // Word count above 16384 is rejected.
    cap_q.delete();
    e0 = err_seen;
    send_byte(8'h44, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h40, 1'b1);
    repeat (4) @(negedge clk);
    chk("big_err", err_seen - e0, 1);
    chk("big_done", upg.upg_done_o, 0);
    chk("big_nwr", cap_q.size(), 0);

`ifdef UPG_CHECKSUM_EN
    e0 = err_seen;
    send_byte(8'h49, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h04, 1'b1);
    repeat (4) @(negedge clk);
    chk("chk_ok_done", upg.upg_done_o, 1);
    chk("chk_ok_err", err_seen - e0, 0);
    e0 = err_seen;
    send_byte(8'h49, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h05, 1'b1);
    repeat (4) @(negedge clk);
    chk("chk_bad_done", upg.upg_done_o, 0);
    chk("chk_bad_err", err_seen - e0, 1);
`endif

    // Randomized frames: random region, length, contents and optional framing error.
    for (int f = 0; f < 6; f++) begin
      tx_words.delete();
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) tx_words.push_back($urandom);
      bp = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4 * n - 1) : -1;
      run_frame("rand", ($urandom_range(0, 1) == 1) ? 8'h44 : 8'h49, bp);
    end

    chk("wen_width", wen_bad, 0);
    chk("err_width", err_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
